prefix_sub_pipe: RTL and testbench
==================================

PREFIX_SUB_PIPE -- requirements
Module: prefix_sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; legal values 4, 8, 16, 32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b presented.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  WIDTH  minuend, unsigned/two's complement.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port out_valid  output  1  result presented.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 SHALL have port borrow  output  1  1 when unsigned a < b.
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow of a - b.
REQ-013 SHALL have port zero  output  1  1 when diff == 0.

Function
REQ-014 SHALL compute a - b as a + ~b + 1: per-bit g = a & ~b, p = a ^ ~b, carry-in fixed 1 folded in as generate of bit -1.
REQ-015 SHALL resolve carries with a parallel-prefix network of log2(WIDTH) levels of (G,P) combine cells: G = Gi | Pi&Gj, P = Pi&Pj.
REQ-016 SHALL form diff[i] = p[i] ^ c[i-1] (c[-1] = 1), borrow = ~carry-out, ovf = c[WIDTH-1] ^ c[WIDTH-2], zero = ~|diff.
REQ-017 SHALL be a 3-stage pipeline: S1 registers g/p, S2 registers prefix carries plus p, S3 registers diff/borrow/ovf/zero.
REQ-018 SHALL produce out_valid exactly 3 cycles after an accepted input when out_ready held 1 (accept at edge N -> out_valid high after edge N+3).
REQ-019 SHALL transfer input on in_valid & in_ready and output on out_valid & out_ready.
REQ-020 SHALL advance each stage k when stage k is empty or stage k+1 advances; in_ready = S1 empty or S1 advances (combinational path from out_ready allowed).
REQ-021 SHALL sustain one result per cycle with out_ready held 1.
REQ-022 SHALL hold diff/borrow/ovf/zero/out_valid stable while out_valid & ~out_ready.
REQ-023 SHALL, with all three stages full and out_ready = 0, drive in_ready = 0 and drop/duplicate nothing.
REQ-024 SHALL, in a full pipeline, accept a new input in the same cycle out_ready rises.
REQ-025 SHALL preserve order; no reordering, no bubbles inserted when not stalled.
REQ-026 SHALL ignore a/b when in_valid = 0; result registers need not change when a stage is empty.

Reset
REQ-027 SHALL clear all stage valid flags on rst; out_valid = 0, diff = 0, borrow = 0, ovf = 0, zero = 0 in the cycle after rst.
REQ-028 SHALL discard in-flight operations on rst asserted mid-operation; none emerge afterwards.
REQ-029 SHALL drive in_ready = 0 while rst = 1 and in_ready = 1 the first cycle after release.

Structure
REQ-030 SHALL place WIDTH legality range and a LEVELS = log2(WIDTH) constant function in shared package prefix_pkg.
REQ-031 SHALL implement the combine operator as one sub-module prefix_gp_cell (inputs Gi, Pi, Gj, Pj; outputs G, P), instantiated by generate loops.
REQ-032 SHALL contain no latches and no asynchronous reset logic.

Verification
REQ-033 SHALL check (WIDTH=8) a=0x05, b=0x05 -> diff=0x00, zero=1, borrow=0, ovf=0, 3 cycles after accept.
REQ-034 SHALL check a=0x00, b=0x01 -> diff=0xFF, borrow=1, ovf=0, zero=0; a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0.
REQ-035 SHALL check back-to-back stream of 256 random pairs, out_ready=1 -> one result per cycle, all match reference model in order.
REQ-036 SHALL check stall: fill 3 entries, out_ready=0 for 5 cycles -> in_ready=0, outputs frozen; then out_ready=1 -> 3 results in order, in_ready=1 same cycle.
REQ-037 SHALL check rst asserted with 2 ops in flight -> out_valid=0 next cycle and no stale result after release.
REQ-038 SHALL check WIDTH=16 and WIDTH=32 exhaustively on corners (0, 1, max, min signed) against a - b model.

Source files
------------

// File: rtl/prefix_pkg.sv
// rtl/prefix_pkg.sv - shared width limits and prefix-depth helper for the subtractor pipe
package prefix_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_legal(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

  // Number of combine levels needed for a prefix span of w bits.
  function automatic int levels(input int w);
    int n;
    n = 0;
    while ((1 << n) < w) n = n + 1;
    return n;
  endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// rtl/prefix_gp_cell.sv - (G,P) combine cell of the parallel-prefix carry network
module prefix_gp_cell (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic g,
  output logic p
);

  assign g = gi | (pi & gj);
  assign p = pi & pj;

endmodule

// File: rtl/prefix_sub_pipe.sv
// rtl/prefix_sub_pipe.sv - 3-stage a-b subtractor with Kogge-Stone carries and valid/ready flow
module prefix_sub_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = levels(WIDTH);

  logic             v1, v2, v3;
  logic             en1, en2, en3;
  logic [WIDTH-1:0] g_in, p_in;
  logic [WIDTH-1:0] g1, p1;
  logic [WIDTH-1:0] c2, p2;
  logic [WIDTH-1:0] d3;
  logic [WIDTH-1:0] gl [0:LEVELS];
  logic [WIDTH-1:0] pl [0:LEVELS];
  logic             unused_p;

  assign en3      = ~v3 | out_ready;
  assign en2      = ~v2 | en3;
  assign en1      = ~v1 | en2;
  assign in_ready = en1 & ~rst;
  assign out_valid = v3;

  // Carry-in of 1 is folded into bit 0 as its generate, so the network needs no extra position.
  always_comb begin
    p_in    = a ^ ~b;
    g_in    = a & ~b;
    g_in[0] = g_in[0] | p_in[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        g1 <= g_in;
        p1 <= p_in;
      end
    end
  end

  assign gl[0] = g1;
  assign pl[0] = p1;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_cell
        prefix_gp_cell u_cell (
          .gi (gl[l][i]),
          .pi (pl[l][i]),
          .gj (gl[l][i-(1<<l)]),
          .pj (pl[l][i-(1<<l)]),
          .g  (gl[l+1][i]),
          .p  (pl[l+1][i])
        );
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        assign pl[l+1][i] = pl[l][i];
      end
    end
  end

  // Final-level group propagate has no consumer.
  assign unused_p = ^pl[LEVELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        c2 <= gl[LEVELS];
        p2 <= p1;
      end
    end
  end

  assign d3 = p2 ^ {c2[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      v3     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (en3) begin
      v3 <= v2;
      if (v2) begin
        diff   <= d3;
        borrow <= ~c2[WIDTH-1];
        ovf    <= c2[WIDTH-1] ^ c2[WIDTH-2];
        zero   <= ~|d3;
      end
    end
  end

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// tb/tb_prefix_sub_pipe.sv - randomized self-checking bench for prefix_sub_pipe
module tb_prefix_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid, in_ready, out_valid, out_ready, borrow, ovf, zero;
  logic [7:0] a, b, diff;
  logic        iv16, ir16, ov16, or16, br16, of16, z16;
  logic [15:0] a16, b16, d16;
  logic        iv32, ir32, ov32, or32, br32, of32, z32;
  logic [31:0] a32, b32, d32;

  prefix_sub_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow),
    .ovf(ovf), .zero(zero)
  );
  prefix_sub_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow(br16),
    .ovf(of16), .zero(z16)
  );
  prefix_sub_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .diff(d32), .borrow(br32),
    .ovf(of32), .zero(z32)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [35:0] exp_q[$];
  bit          accepted, popped, ir_seen;
  logic [36:0] out_seen;
  logic [35:0] last_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result packed as {0, borrow, ovf, zero, diff zero-extended to 32}.
  function automatic logic [35:0] ref_sub(input int w, input logic [31:0] x, input logic [31:0] y);
    longint one, mask, ux, uy, sx, sy, sd, lim, d;
    logic [35:0] r;
    one  = 1;
    mask = (one << w) - 1;
    ux   = {32'b0, x} & mask;
    uy   = {32'b0, y} & mask;
    sx   = x[w-1] ? ux - (one << w) : ux;
    sy   = y[w-1] ? uy - (one << w) : uy;
    sd   = sx - sy;
    lim  = one << (w - 1);
    d    = (ux - uy) & mask;
    r        = '0;
    r[31:0]  = d[31:0];
    r[32]    = (d == 0);
    r[33]    = (sd >= lim) || (sd < -lim);
    r[34]    = (ux < uy);
    return r;
  endfunction

  task automatic cyc8(input bit iv, input logic [7:0] xa, input logic [7:0] xb, input bit ordy);
    logic [35:0] e;
    @(negedge clk);
    in_valid  = iv;
    a         = xa;
    b         = xb;
    out_ready = ordy;
    #1;
    popped   = 1'b0;
    accepted = 1'b0;
    ir_seen  = in_ready;
    out_seen = {out_valid, 1'b0, borrow, ovf, zero, 24'h0, diff};
    if (out_valid && out_ready) begin
      popped   = 1'b1;
      last_out = {1'b0, borrow, ovf, zero, 24'h0, diff};
      if (exp_q.size() == 0) begin
        check("stale_out", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(last_out), 64'(e));
      end
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      exp_q.push_back(ref_sub(8, 32'(xa), 32'(xb)));
    end
    @(posedge clk);
  endtask

  task automatic drain8();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc8(1'b0, 8'($urandom), 8'($urandom), 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic dir8(input string tag, input logic [7:0] xa, input logic [7:0] xb, input logic [35:0] want);
    int lat;
    cyc8(1'b1, xa, xb, 1'b1);
    check({tag, "_accept"}, 64'(accepted), 64'(1));
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc8(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      if (popped) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(3));
    check({tag, "_value"}, 64'(last_out), 64'(want));
  endtask

  logic [15:0] cv16 [0:3];
  logic [31:0] cv32 [0:3];
  logic [36:0] snap;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({borrow, ovf, zero, diff}), 64'(0));
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'(1));
    check("release_in_ready16", 64'(ir16), 64'(1));

    dir8("sub_5_5", 8'h05, 8'h05, 36'h1_0000_0000);
    dir8("sub_0_1", 8'h00, 8'h01, 36'h4_0000_00FF);
    dir8("sub_80_1", 8'h80, 8'h01, 36'h2_0000_007F);

    for (int i = 0; i < 256; i++) begin
      cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      check("stream_accept", 64'(accepted), 64'(1));
      if (i >= 3) check("stream_rate", 64'(popped), 64'(1));
    end
    drain8();

    for (int k = 0; k < 3; k++) begin
      cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      check("stall_fill", 64'(accepted), 64'(1));
    end
    snap = '0;
    for (int k = 0; k < 5; k++) begin
      cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      if (k == 0) begin
        snap = out_seen;
        check("stall_head", 64'(snap), 64'({1'b1, exp_q[0]}));
      end
      check("stall_in_ready", 64'(ir_seen), 64'(0));
      check("stall_accept", 64'(accepted), 64'(0));
      check("stall_hold", 64'(out_seen), 64'(snap));
    end
    cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    check("resume_in_ready", 64'(ir_seen), 64'(1));
    check("resume_pop", 64'(popped), 64'(1));
    for (int k = 0; k < 2; k++) begin
      cyc8(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      check("resume_order", 64'(popped), 64'(1));
    end
    drain8();

    for (int i = 0; i < 300; i++)
      cyc8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    drain8();

    cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_outputs", 64'({borrow, ovf, zero, diff}), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_release", 64'(in_ready), 64'(1));
    for (int k = 0; k < 8; k++) begin
      cyc8(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      check("no_stale", 64'(popped), 64'(0));
    end

    cv16[0] = 16'h0000; cv16[1] = 16'h0001; cv16[2] = 16'hFFFF; cv16[3] = 16'h8000;
    cv32[0] = 32'h0;    cv32[1] = 32'h1;    cv32[2] = 32'hFFFF_FFFF; cv32[3] = 32'h8000_0000;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      iv16 = (i < 16);
      iv32 = (i < 16);
      if (i < 16) begin
        a16 = cv16[i/4]; b16 = cv16[i%4];
        a32 = cv32[i/4]; b32 = cv32[i%4];
      end
      #1;
      if (i >= 3) begin
        check("w16_valid", 64'(ov16), 64'(1));
        check("w16_result", 64'({1'b0, br16, of16, z16, 16'h0, d16}),
              64'(ref_sub(16, 32'(cv16[(i-3)/4]), 32'(cv16[(i-3)%4]))));
        check("w32_valid", 64'(ov32), 64'(1));
        check("w32_result", 64'({1'b0, br32, of32, z32, d32}),
              64'(ref_sub(32, cv32[(i-3)/4], cv32[(i-3)%4])));
      end else begin
        check("w16_latency", 64'(ov16), 64'(0));
        check("w32_latency", 64'(ov32), 64'(0));
      end
      @(posedge clk);
    end
    @(negedge clk);
    iv16 = 1'b0;
    iv32 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
